// File: rtl/dvi_timing_pkg.sv
// Shared constants and types for the DVI timing generator: 1024x768@60 defaults,
// lock-qualifier FSM states and the colour-bar palette.
package dvi_timing_pkg;

  localparam int DEF_H_ACTIVE  = 1024;
  localparam int DEF_H_FP      = 24;
  localparam int DEF_H_SYNC    = 136;
  localparam int DEF_H_BP      = 160;
  localparam int DEF_V_ACTIVE  = 768;
  localparam int DEF_V_FP      = 3;
  localparam int DEF_V_SYNC    = 6;
  localparam int DEF_V_BP      = 29;
  localparam int DEF_LOCK_WAIT = 1024;

  localparam int CNT_W = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } lock_state_e;

  // Index 0 is the leftmost bar on screen.
  localparam logic [0:7][23:0] COLOR_BARS = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/dvi_lock_qual.sv
// PLL lock qualifier: 2-flop synchronizer, consecutive-lock counter and the
// WAIT_LOCK/RUN FSM; run_en_o is high while the FSM is in RUN.
module dvi_lock_qual
  import dvi_timing_pkg::*;
#(
  parameter int LOCK_WAIT = DEF_LOCK_WAIT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic lock_i,
  output logic run_en_o
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);

  if (LOCK_WAIT < 1 || LOCK_WAIT > CNT_MAX + 1) begin : g_lock_wait_chk
    $error("LOCK_WAIT must lie in 1..4096");
  end

  logic              sync1_q;
  logic              sync2_q;
  logic              lock_s;
  lock_state_e       state_q;
  lock_state_e       state_d;
  logic [CNT_W-1:0]  lock_cnt_q;
  logic [CNT_W-1:0]  lock_cnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
    end else begin
      sync1_q    <= lock_i;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign lock_s = sync2_q;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (!lock_s) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d    = RUN;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d    = WAIT_LOCK;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        lock_cnt_d = '0;
      end
    endcase
  end

  assign run_en_o = (state_q == RUN);

endmodule

// File: rtl/dvi_timing_gen.sv
// DVI video timing generator: registered syncs, data enable and pixel coordinates.
// Colour-bar rgb output is built only when DVI_TIMING_TEST_PATTERN_EN is defined.
module dvi_timing_gen
  import dvi_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int LOCK_WAIT = DEF_LOCK_WAIT
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             lock,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
`ifdef DVI_TIMING_TEST_PATTERN_EN
  output logic [23:0]      rgb,
`endif
  output logic             running
);

  localparam int H_TOTAL_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL_I > CNT_MAX || H_ACTIVE < 1) begin : g_h_total_chk
    $error("horizontal timing total must lie in 1..4095");
  end
  if (V_TOTAL_I > CNT_MAX || V_ACTIVE < 1) begin : g_v_total_chk
    $error("vertical timing total must lie in 1..4095");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL_I - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL_I - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic             run_en;
  logic [CNT_W-1:0] h_cnt_q;
  logic [CNT_W-1:0] h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q;
  logic [CNT_W-1:0] v_cnt_d;

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             running_q, running_d;

  dvi_lock_qual #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_qual (
    .clk_i    (clkin),
    .reset_i  (reset),
    .lock_i   (lock),
    .run_en_o (run_en)
  );

  // Counters sit at zero outside RUN, so the first RUN cycle is h=0, v=0.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!run_en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end else begin
      h_cnt_d = h_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    de_d          = run_en && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    x_d           = de_d ? h_cnt_q : '0;
    y_d           = de_d ? v_cnt_q : '0;
    hsync_d       = (run_en && in_range(h_cnt_q, HS_START, HS_END)) ? HS_POL : ~HS_POL;
    vsync_d       = (run_en && in_range(v_cnt_q, VS_START, VS_END)) ? VS_POL : ~VS_POL;
    line_start_d  = run_en && (h_cnt_q == '0);
    frame_start_d = line_start_d && (v_cnt_q == '0);
    running_d     = run_en;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

`ifdef DVI_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  if (H_ACTIVE % 8 != 0) begin : g_bar_chk
    $error("H_ACTIVE must be divisible by 8 for the colour-bar pattern");
  end

  logic [2:0]  bar_idx;
  logic [23:0] rgb_q;
  logic [23:0] rgb_d;

  // Bar index from a compare chain against the bar boundaries.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt_q >= CNT_W'(k * BAR_W)) begin
        bar_idx = 3'(k);
      end
    end
    rgb_d = de_d ? COLOR_BARS[bar_idx] : 24'h0;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      rgb_q <= 24'h0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;
`endif

endmodule
